int_sequencer: RTL and testbench

Interrupt entry sequencer that sits directly upstream of the fetch and decode stages. It detects an external interrupt request and waits for the pipeline to drain. It then pushes the return PC (and optionally the flags) through the memory-stage push path, reads the 32-bit ISR vector from data memory, and forces a PC load into fetch. While a sequence is active it drives `interrupt_signal` into decode so that decode injects bubbles.

---
 rtl/int_pkg.sv | 32 +++
 rtl/irq_edge_latch.sv | 35 +++
 rtl/int_sequencer.sv | 151 +++++++++++++++
 tb/tb_int_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt entry sequencer.
// The flag-save feature is selected by the INT_FLAGS_SAVE_EN macro in int_sequencer.
package int_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_PUSH_PC_HI,
        ST_PUSH_PC_LO,
        ST_PUSH_FLAGS,
        ST_VEC_HI,
        ST_VEC_LO,
        ST_JUMP
    } int_state_t;

    localparam logic [15:0] INT_VEC_ADDR_DEFAULT = 16'h0000;

    localparam int FLAG_Z_BIT = 2;
    localparam int FLAG_N_BIT = 1;
    localparam int FLAG_C_BIT = 0;

    // Places the Z/N/C flags at their architectural bit positions in a stack word.
    function automatic logic [15:0] flags_word(input logic [2:0] flags);
        logic [15:0] w;
        w             = '0;
        w[FLAG_Z_BIT] = flags[FLAG_Z_BIT];
        w[FLAG_N_BIT] = flags[FLAG_N_BIT];
        w[FLAG_C_BIT] = flags[FLAG_C_BIT];
        return w;
    endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge detector on the external interrupt line with a single-entry pending latch.
// Edges arriving while a request is already pending are dropped.
module irq_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    input  logic clr,
    output logic req
);

    logic irq_d_q;
    logic irq_d_d;
    logic pending_q;
    logic pending_d;
    logic irq_edge;

    always_comb begin
        irq_edge  = irq_in & ~irq_d_q;
        irq_d_d   = irq_in;
        pending_d = clr ? 1'b0 : (pending_q | irq_edge);
        // The edge itself counts so the sequencer can leave IDLE in the detection cycle.
        req       = pending_q | irq_edge;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_d_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            irq_d_q   <= irq_d_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt entry sequencer: drain, push return PC (and flags when INT_FLAGS_SAVE_EN
// is defined), fetch the 32-bit ISR vector from data memory and force a PC load.
module int_sequencer
    import int_pkg::*;
#(
    parameter logic [15:0] VEC_ADDR     = INT_VEC_ADDR_DEFAULT,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq_in,
    input  logic        stall,
    input  logic        branch_in_flight,
    input  logic [31:0] pc_next,
    input  logic [2:0]  flags_in,
    input  logic        push_ready,
    input  logic [15:0] mem_read_data,
    output logic        interrupt_signal,
    output logic        fetch_hold,
    output logic        push_valid,
    output logic [15:0] push_data,
    output logic        vec_read,
    output logic [15:0] vec_addr,
    output logic        pc_load,
    output logic [31:0] pc_load_value,
    output logic        busy
);

    localparam int               CNT_W     = $clog2(DRAIN_CYCLES + 2);
    localparam logic [CNT_W-1:0] DRAIN_MAX = CNT_W'(DRAIN_CYCLES);

    int_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pc_q, pc_d;
    logic [15:0]      vec_hi_q, vec_hi_d;
    logic             pend_req;
    logic             pend_clr;

`ifdef INT_FLAGS_SAVE_EN
    logic [2:0]       flags_q, flags_d;
`else
    logic             unused_flags;
    assign unused_flags = ^flags_word(flags_in);
`endif

    irq_edge_latch u_edge (
        .clk    (clk),
        .rst    (rst),
        .irq_in (irq_in),
        .clr    (pend_clr),
        .req    (pend_req)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        pc_d          = pc_q;
        vec_hi_d      = vec_hi_q;
        pend_clr      = 1'b0;
        push_valid    = 1'b0;
        push_data     = '0;
        vec_read      = 1'b0;
        vec_addr      = '0;
        pc_load       = 1'b0;
        pc_load_value = '0;
`ifdef INT_FLAGS_SAVE_EN
        flags_d       = flags_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pend_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_MAX) begin
                    pc_d     = pc_next;
`ifdef INT_FLAGS_SAVE_EN
                    flags_d  = flags_in;
`endif
                    pend_clr = 1'b1;
                    state_d  = ST_PUSH_PC_HI;
                end else if (!stall && !branch_in_flight) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PUSH_PC_HI: begin
                push_valid = 1'b1;
                push_data  = pc_q[31:16];
                if (push_ready) state_d = ST_PUSH_PC_LO;
            end
            ST_PUSH_PC_LO: begin
                push_valid = 1'b1;
                push_data  = pc_q[15:0];
`ifdef INT_FLAGS_SAVE_EN
                if (push_ready) state_d = ST_PUSH_FLAGS;
`else
                if (push_ready) state_d = ST_VEC_HI;
`endif
            end
`ifdef INT_FLAGS_SAVE_EN
            ST_PUSH_FLAGS: begin
                push_valid = 1'b1;
                push_data  = flags_word(flags_q);
                if (push_ready) state_d = ST_VEC_HI;
            end
`endif
            ST_VEC_HI: begin
                vec_read = 1'b1;
                vec_addr = VEC_ADDR;
                state_d  = ST_VEC_LO;
            end
            ST_VEC_LO: begin
                // Read data for the high half arrives now, one cycle after its request.
                vec_read = 1'b1;
                vec_addr = VEC_ADDR + 16'd1;
                vec_hi_d = mem_read_data;
                state_d  = ST_JUMP;
            end
            ST_JUMP: begin
                pc_load       = 1'b1;
                pc_load_value = {vec_hi_q, mem_read_data};
                state_d       = pend_req ? ST_DRAIN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign interrupt_signal = (state_q != ST_IDLE);
    assign busy             = interrupt_signal;
    assign fetch_hold       = (state_q != ST_IDLE) && (state_q != ST_JUMP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pc_q     <= '0;
            vec_hi_q <= '0;
`ifdef INT_FLAGS_SAVE_EN
            flags_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            vec_hi_q <= vec_hi_d;
`ifdef INT_FLAGS_SAVE_EN
            flags_q  <= flags_d;
`endif
        end
    end

endmodule

// File: tb/tb_int_sequencer.sv
// Scoreboard bench for int_sequencer: directed timing scenarios plus randomized entries.
module tb_int_sequencer;

    localparam int D = 3;
`ifdef INT_FLAGS_SAVE_EN
    localparam int NP = 3;
`else
    localparam int NP = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        irq_in;
    logic        stall;
    logic        branch_in_flight;
    logic [31:0] pc_next;
    logic [2:0]  flags_in;
    logic        push_ready;
    logic [15:0] mem_read_data;
    logic        interrupt_signal;
    logic        fetch_hold;
    logic        push_valid;
    logic [15:0] push_data;
    logic        vec_read;
    logic [15:0] vec_addr;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        busy;

    always #5 clk = ~clk;

    int_sequencer #(.VEC_ADDR(16'h0000), .DRAIN_CYCLES(D)) dut (
        .clk              (clk),
        .rst              (rst),
        .irq_in           (irq_in),
        .stall            (stall),
        .branch_in_flight (branch_in_flight),
        .pc_next          (pc_next),
        .flags_in         (flags_in),
        .push_ready       (push_ready),
        .mem_read_data    (mem_read_data),
        .interrupt_signal (interrupt_signal),
        .fetch_hold       (fetch_hold),
        .push_valid       (push_valid),
        .push_data        (push_data),
        .vec_read         (vec_read),
        .vec_addr         (vec_addr),
        .pc_load          (pc_load),
        .pc_load_value    (pc_load_value),
        .busy             (busy)
    );

    typedef struct {
        logic [31:0] value;
        int          cyc;
        bit          busy_after;
    } jump_t;

    logic [15:0] exp_push[$];
    jump_t       exp_jump[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [15:0] mem0, mem1;

    // Data memory: two vector words, 1-cycle read latency, junk when not addressed.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (vec_read && vec_addr == 16'h0000)      mem_read_data <= mem0;
        else if (vec_read && vec_addr == 16'h0001) mem_read_data <= mem1;
        else                                       mem_read_data <= 16'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops expected pushes and jumps as the DUT presents them.
    initial begin : monitor
        bit    busy_armed;
        bit    busy_val;
        jump_t j;
        logic [15:0] e;
        busy_armed = 0;
        busy_val   = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) continue;
            if (busy_armed) begin
                chk("busy_after_jump", 32'(busy), 32'(busy_val));
                busy_armed = 0;
            end
            chk("int_sig_eq_busy", 32'(interrupt_signal), 32'(busy));
            chk("fetch_hold", 32'(fetch_hold), 32'(busy & ~pc_load));
            if (push_valid && push_ready) begin
                if (exp_push.size() == 0) begin
                    chk("unexpected_push", 32'(push_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_push.pop_front();
                    chk("push_data", 32'(push_data), 32'(e));
                end
            end
            if (pc_load) begin
                if (exp_jump.size() == 0) begin
                    chk("unexpected_pc_load", pc_load_value, 32'hFFFF_FFFF);
                end else begin
                    j = exp_jump.pop_front();
                    chk("pc_load_value", pc_load_value, j.value);
                    if (j.cyc >= 0) chk("pc_load_cycle", 32'(cyc), 32'(j.cyc));
                    busy_armed = 1;
                    busy_val   = j.busy_after;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; irq_in = 1'b0; stall = 1'b0; branch_in_flight = 1'b0; push_ready = 1'b0;
        repeat (n) step();
        rst = 1'b0;
        exp_push.delete();
        exp_jump.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_busy"},          32'(busy), 32'd0);
        chk({name, "_int_sig"},       32'(interrupt_signal), 32'd0);
        chk({name, "_fetch_hold"},    32'(fetch_hold), 32'd0);
        chk({name, "_push_valid"},    32'(push_valid), 32'd0);
        chk({name, "_push_data"},     32'(push_data), 32'd0);
        chk({name, "_vec_read"},      32'(vec_read), 32'd0);
        chk({name, "_vec_addr"},      32'(vec_addr), 32'd0);
        chk({name, "_pc_load"},       32'(pc_load), 32'd0);
        chk({name, "_pc_load_value"}, pc_load_value, 32'd0);
    endtask

    task automatic push_expected(input logic [31:0] pc, input logic [2:0] fl);
        exp_push.push_back(pc[31:16]);
        exp_push.push_back(pc[15:0]);
`ifdef INT_FLAGS_SAVE_EN
        exp_push.push_back({13'b0, fl});
`else
        if (fl === 3'bxxx) $display("note: flags unknown");
`endif
    endtask

    // Cycle 0 raises irq_in; DRAIN is cycle 1; with a stall in drain cycle k the
    // counter restarts after it, so PUSH_PC_HI lands at k+D+3 instead of D+2.
    task automatic run_directed(input string name, input int stall_k, input int hold_n,
                                input bit nest, input bit rst_mid, input logic [31:0] pc,
                                input logic [2:0] fl, input logic [15:0] m0, input logic [15:0] m1);
        int    base, push_c, jump_c, jump2_c, end_c;
        jump_t j;
        base    = cyc;
        push_c  = (stall_k >= 0) ? stall_k + D + 3 : D + 2;
        jump_c  = push_c + hold_n + NP + 2;
        jump2_c = jump_c + D + NP + 4;
        end_c   = nest ? jump2_c + 3 : (rst_mid ? push_c + 8 : jump_c + 3);
        pc_next = pc; flags_in = fl; mem0 = m0; mem1 = m1;
        stall = 1'b0; branch_in_flight = 1'b0; push_ready = 1'b1;
        if (rst_mid) begin
            exp_push.push_back(pc[31:16]);
        end else begin
            push_expected(pc, fl);
            j.value = {m0, m1}; j.cyc = base + jump_c; j.busy_after = nest;
            exp_jump.push_back(j);
        end
        if (nest) begin
            push_expected(pc, fl);
            j.value = {m0, m1}; j.cyc = base + jump2_c; j.busy_after = 1'b0;
            exp_jump.push_back(j);
        end
        irq_in = 1'b1;
        for (int c = 1; c <= end_c; c++) begin
            step();
            irq_in = (c < 2);
            if (nest && (c == push_c + NP || c == jump_c)) irq_in = 1'b1;
            if (rst_mid && c == push_c) irq_in = 1'b1;
            stall            = (stall_k >= 0 && c == 1 + stall_k) ||
                               (!rst_mid && c >= push_c && c <= jump_c);
            branch_in_flight = !rst_mid && c >= push_c && c <= jump_c;
            push_ready       = !(hold_n > 0 && c >= push_c && c < push_c + hold_n);
            rst              = rst_mid && c == push_c + 1;
            if (c == 1) chk({name, "_drain_entry"}, 32'(busy), 32'd1);
            if (c == push_c - 1) chk({name, "_no_push_yet"}, 32'(push_valid), 32'd0);
            if (c >= push_c && c < push_c + (hold_n > 0 ? hold_n : 1)) begin
                chk({name, "_push_valid_hi"}, 32'(push_valid), 32'd1);
                chk({name, "_push_data_hi"}, 32'(push_data), 32'(pc[31:16]));
            end
            if (rst_mid && c == push_c + 2) check_idle_outputs({name, "_after_rst"});
            if (rst_mid && c > push_c + 2) chk({name, "_pending_cleared"}, 32'(busy), 32'd0);
        end
        irq_in = 1'b0; stall = 1'b0; branch_in_flight = 1'b0; push_ready = 1'b1; rst = 1'b0;
        step();
        chk({name, "_push_queue_empty"}, 32'(exp_push.size()), 32'd0);
        chk({name, "_jump_queue_empty"}, 32'(exp_jump.size()), 32'd0);
        exp_push.delete();
        exp_jump.delete();
        step();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog global time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        jump_t       j;
        logic [31:0] pc;
        logic [2:0]  fl;
        int          n;
        pc_next = '0; flags_in = '0; mem0 = '0; mem1 = '0;
        do_reset(3);
        check_idle_outputs("reset");
        repeat (2) step();

        run_directed("basic",   -1, 0, 0, 0, 32'h0000_0123, 3'b101, 16'h0000, 16'h0040);
        run_directed("stall2",   1, 0, 0, 0, 32'hDEAD_BEEF, 3'b010, 16'h1234, 16'h5678);
        run_directed("hold4",   -1, 4, 0, 0, 32'hA5A5_0F0F, 3'b111, 16'hCAFE, 16'hF00D);
        run_directed("nest",    -1, 0, 1, 0, 32'h0101_2020, 3'b001, 16'h0BAD, 16'hC0DE);
        run_directed("rst_mid", -1, 0, 0, 1, 32'h7777_8888, 3'b100, 16'h1111, 16'h2222);

        for (int t = 0; t < 40; t++) begin
            pc   = $urandom;
            fl   = 3'($urandom);
            mem0 = 16'($urandom);
            mem1 = 16'($urandom);
            pc_next  = pc;
            flags_in = fl;
            push_expected(pc, fl);
            j.value = {mem0, mem1}; j.cyc = -1; j.busy_after = 1'b0;
            exp_jump.push_back(j);
            irq_in = 1'b1;
            n = 0;
            while (exp_jump.size() != 0 && n < 300) begin
                step();
                stall            = ($urandom_range(0, 3) == 0);
                branch_in_flight = ($urandom_range(0, 3) == 0);
                push_ready       = ($urandom_range(0, 2) != 0);
                n++;
            end
            if (exp_jump.size() != 0) begin
                checks++;
                failures++;
                $display("FAIL random_timeout txn=%0d actual=no_pc_load required=pc_load", t);
                do_reset(2);
            end
            irq_in = 1'b0; stall = 1'b0; branch_in_flight = 1'b0; push_ready = 1'b1;
            repeat (3) step();
            chk("random_push_queue_empty", 32'(exp_push.size()), 32'd0);
            exp_push.delete();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
